data_split: RTL and testbench

//  Serializer from words to bytes; the inverse of the flash-read byte concatenator.

---
 rtl/data_split.sv | 111 +++++++++++
 tb/tb_data_split.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_split.sv
// Word-to-byte serializer: one word in the shift register plus one pending word, emitted LSB byte first.
// Optional checksum byte per word when DATA_SPLIT_CHKSUM_EN is defined.
module data_split #(
    parameter int WORD_W = 256
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              in_en,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              byte_req,
    output logic              tx_flag,
    output logic [7:0]        tx_data,
    output logic              word_done,
    output logic              busy
);
    localparam int NBYTES = WORD_W / 8;
`ifdef DATA_SPLIT_CHKSUM_EN
    localparam int LAST  = NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
`else
    localparam int LAST  = NBYTES - 1;
`endif
    localparam int CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [WORD_W-1:0]  sh_data;
    logic [WORD_W-1:0]  pend_data;
    logic               pend_valid;
    logic [7:0]         cur_byte;
    logic               accept;
    logic               last_byte;

    assign in_ready  = !pend_valid;
    assign accept    = in_en && in_ready;
    assign last_byte = (state == SEND) && byte_req && (byte_cnt == CNT_W'(LAST));

`ifdef DATA_SPLIT_CHKSUM_EN
    logic [7:0] chk_byte;

    always_comb begin
        chk_byte = '0;
        for (int k = 0; k < NBYTES; k++)
            chk_byte = chk_byte ^ sh_data[8*k +: 8];
    end

    // The slot after the last data byte carries the XOR of the whole word.
    assign cur_byte = (byte_cnt == CNT_W'(NBYTES)) ? chk_byte
                                                   : sh_data[8*byte_cnt[IDX_W-1:0] +: 8];
`else
    assign cur_byte = sh_data[8*byte_cnt +: 8];
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            sh_data    <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            tx_flag    <= 1'b0;
            tx_data    <= '0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tx_flag   <= 1'b0;
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_data  <= in_data;
                        byte_cnt <= '0;
                        state    <= SEND;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (byte_req) begin
                        tx_flag  <= 1'b1;
                        tx_data  <= cur_byte;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    // On the last byte the next word is loaded so its byte 0 follows without a bubble.
                    if (last_byte) begin
                        word_done <= 1'b1;
                        byte_cnt  <= '0;
                        if (pend_valid) begin
                            sh_data <= pend_data;
                            if (accept)
                                pend_data <= in_data;
                            else
                                pend_valid <= 1'b0;
                        end else if (accept) begin
                            sh_data <= in_data;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (accept) begin
                        pend_data  <= in_data;
                        pend_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_split.sv
// Bench for data_split: byte scoreboard plus word-level reassembly (loopback) check.
module tb_data_split;
    localparam int W  = 256;
    localparam int NB = W / 8;
`ifdef DATA_SPLIT_CHKSUM_EN
    localparam int SPW = NB + 1;
`else
    localparam int SPW = NB;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         in_en = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         byte_req = 1'b1;
    logic         tx_flag;
    logic [7:0]   tx_data;
    logic         word_done;
    logic         busy;

    exp_t         exp_q[$];
    logic [W-1:0] word_q[$];
    int           wd_cyc[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           popped = 0;
    int           bk = 0;
    logic         req_q = 1'b0;
    logic [W-1:0] asm_w = '0;
    exp_t         e;
    logic [W-1:0] mw;

    data_split #(.WORD_W(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_en     (in_en),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .byte_req  (byte_req),
        .tx_flag   (tx_flag),
        .tx_data   (tx_data),
        .word_done (word_done),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc   <= cyc + 1;
        req_q <= byte_req;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: every strobe must match the head of the byte scoreboard.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            bk = 0;
        end else begin
            if (word_done)
                check("done_without_flag", W'(tx_flag), W'(1));
            if (tx_flag) begin
                check("strobe_without_req", W'(req_q), W'(1));
                check("spurious_strobe", W'(exp_q.size() > 0), W'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("byte", W'(tx_data), W'(e.d));
                    check("word_done", W'(word_done), W'(e.last));
                    popped++;
                end
                if (bk < NB) asm_w[8*bk +: 8] = tx_data;
                bk++;
                if (word_done) begin
                    wd_cyc.push_back(cyc);
                    if (word_q.size() > 0) begin
                        mw = word_q.pop_front();
                        check("loopback_word", asm_w, mw);
                    end
                    bk = 0;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with in_en still high.
    task automatic send_word(input logic [W-1:0] w);
        int t = 0;
        logic [7:0] x = '0;
        in_en   = 1'b1;
        in_data = w;
        while (!in_ready && t < 500) begin
            @(negedge sys_clk);
            t++;
        end
        check("accept_timeout", W'(in_ready), W'(1));
        for (int k = 0; k < NB; k++) begin
            exp_q.push_back('{d: w[8*k +: 8], last: (k == SPW - 1)});
            x = x ^ w[8*k +: 8];
        end
`ifdef DATA_SPLIT_CHKSUM_EN
        exp_q.push_back('{d: x, last: 1'b1});
`endif
        word_q.push_back(w);
        @(negedge sys_clk);
    endtask

    task automatic wait_drain(input int lim, input logic rnd_req);
        int t = 0;
        while (exp_q.size() > 0 && t < lim) begin
            @(negedge sys_clk);
            if (rnd_req) byte_req = 1'($urandom_range(0, 1));
            t++;
        end
        byte_req = 1'b1;
        check("drain_timeout", W'(exp_q.size()), W'(0));
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [W-1:0] w;
        int t;

        // Reset state
        repeat (5) @(negedge sys_clk);
        check("rst_tx_flag", W'(tx_flag), W'(0));
        check("rst_tx_data", W'(tx_data), W'(0));
        check("rst_word_done", W'(word_done), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Single word, byte k = k, latency and order
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'(k);
        send_word(w);
        in_en = 1'b0;
        check("lat_no_flag_yet", W'(tx_flag), W'(0));
        @(negedge sys_clk);
        check("lat_first_flag", W'(tx_flag), W'(1));
        check("lat_first_byte", W'(tx_data), W'(0));
        wait_drain(100, 1'b0);
        @(negedge sys_clk);
        check("idle_busy", W'(busy), W'(0));
        check("idle_in_ready", W'(in_ready), W'(1));

        // Same word with byte_req alternating
        send_word(w);
        in_en = 1'b0;
        t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(negedge sys_clk);
            byte_req = ~byte_req;
            t++;
        end
        byte_req = 1'b1;
        check("alt_drain", W'(exp_q.size()), W'(0));
        repeat (3) @(negedge sys_clk);

        // Three words back to back, gapless
        wd_cyc.delete();
        send_word(rand_word());
        send_word(rand_word());
        check("ready_low_after_2nd", W'(in_ready), W'(0));
        send_word(rand_word());
        in_en = 1'b0;
        wait_drain(300, 1'b0);
        @(negedge sys_clk);
        check("stream_done_count", W'(wd_cyc.size()), W'(3));
        if (wd_cyc.size() == 3) begin
            check("stream_gap_1", W'(wd_cyc[1] - wd_cyc[0]), W'(SPW));
            check("stream_gap_2", W'(wd_cyc[2] - wd_cyc[1]), W'(SPW));
        end
        check("stream_busy_end", W'(busy), W'(0));

        // Reset in the middle of a word
        popped = 0;
        send_word(rand_word());
        in_en = 1'b0;
        t = 0;
        while (popped < 10 && t < 100) begin
            @(negedge sys_clk);
            t++;
        end
        check("rst_mid_reached", W'(popped >= 10), W'(1));
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        exp_q.delete();
        word_q.delete();
        #1;
        check("rst_mid_tx_flag", W'(tx_flag), W'(0));
        check("rst_mid_in_ready", W'(in_ready), W'(1));
        check("rst_mid_busy", W'(busy), W'(0));
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        check("post_rst_tx_flag", W'(tx_flag), W'(0));
        check("post_rst_busy", W'(busy), W'(0));

        // Loopback of random words with random byte_req
        for (int i = 0; i < 3; i++) begin
            send_word(rand_word());
            send_word(rand_word());
            in_en = 1'b0;
            wait_drain(2000, 1'b1);
        end
        check("loopback_words_left", W'(word_q.size()), W'(0));

`ifdef DATA_SPLIT_CHKSUM_EN
        w = '0;
        w[7:0] = 8'h5A;
        send_word(w);
        in_en = 1'b0;
        wait_drain(100, 1'b0);
`endif

        repeat (3) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
